// File: rtl/pe_pkg.sv
// Shared PE constants and the filter-spad controller state encoding.
package pe_pkg;

  localparam int FILT_SPAD_DEPTH = 224;
  localparam int FILT_ADDR_W     = 8;
  localparam int DATA_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } filt_ctrl_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that returns to zero after reaching a programmable limit value.
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         wrap
);

  // wrap marks the increment that rolls count from limit back to zero
  assign wrap = inc && (count == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/filter_spad_ctrl.sv
// Filter scratch-pad controller: loads weights from the NoC, then replays
// them to the MAC a programmed number of passes.
module filter_spad_ctrl #(
  parameter int ADDR_W = pe_pkg::FILT_ADDR_W,
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int DEPTH  = pe_pkg::FILT_SPAD_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic [7:0]        cfg_reps,
  input  logic              cfg_skip_load,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  output logic [DATA_W-1:0] spad_wdata,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last,
  output logic              done
);
  import pe_pkg::*;

  filt_ctrl_state_t  state, state_nx;
  logic [ADDR_W-1:0] len_q, len_m1;
  logic [7:0]        reps_q, reps_m1;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        rep_cnt;
  logic              loaded_q, err_q;
  logic              cmd_acc, cmd_bad, cmd_go;
  logic              wr_acc, wr_done, rd_acc, rd_wrap, rep_wrap;

  assign cmd_acc = cfg_valid && (state == IDLE);
  assign cmd_bad = (cfg_len == '0)
                || ({1'b0, cfg_len} > (ADDR_W+1)'(DEPTH))
                || (cfg_reps == 8'd0)
                || (cfg_skip_load && !loaded_q);
  assign cmd_go  = cmd_acc && !cmd_bad;

  assign len_m1  = len_q - ADDR_W'(1);
  assign reps_m1 = reps_q - 8'd1;

  assign wr_acc  = (state == LOAD) && in_valid;
  assign wr_done = wr_acc && (wr_ptr == len_m1);
  assign rd_acc  = (state == READ) && w_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cmd_go) state_nx = cfg_skip_load ? READ : LOAD;
      LOAD:    if (wr_done) state_nx = READ;
      READ:    if (rep_wrap) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= cmd_acc && cmd_bad;
      if (cmd_go) begin
        wr_ptr <= '0;
      end else if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      // a fresh load invalidates old contents until it completes
      if (cmd_go && !cfg_skip_load) begin
        loaded_q <= 1'b0;
      end else if (wr_done) begin
        loaded_q <= 1'b1;
      end
    end
  end

  // command fields are plain data; only ever used after a legal accept
  always_ff @(posedge clk) begin
    if (cmd_go) begin
      len_q  <= cfg_len;
      reps_q <= cfg_reps;
    end
  end

  wrap_counter #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cmd_go),
    .inc   (rd_acc),
    .limit (len_m1),
    .count (rd_ptr),
    .wrap  (rd_wrap)
  );

  // the final pass wraps exactly on the handshake that carries w_last
  wrap_counter #(.W(8)) u_rep_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cmd_go),
    .inc   (rd_wrap),
    .limit (reps_m1),
    .count (rep_cnt),
    .wrap  (rep_wrap)
  );

  always_comb begin
    spad_addr = '0;
    case (state)
      LOAD:    spad_addr = wr_ptr;
      READ:    spad_addr = rd_ptr;
      default: spad_addr = '0;
    endcase
  end

  assign cfg_ready  = (state == IDLE);
  assign cfg_err    = err_q;
  assign in_ready   = (state == LOAD);
  assign spad_we    = wr_acc;
  assign spad_wdata = (state == LOAD) ? in_data : '0;
  assign w_valid    = (state == READ);
  assign w_last     = (state == READ) && (rd_ptr == len_m1) && (rep_cnt == reps_m1);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Directed bench for filter_spad_ctrl with a behavioural negedge spad model.
module tb_filter_spad_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready, cfg_skip_load, cfg_err;
  logic [7:0]  cfg_len, cfg_reps;
  logic        in_valid, in_ready;
  logic [15:0] in_data;
  logic [7:0]  spad_addr;
  logic        spad_we;
  logic [15:0] spad_wdata;
  logic        w_valid, w_ready, w_last, done;

  logic [15:0] spad_mem [0:255];
  logic [15:0] spad_dout;
  logic [15:0] exp_w [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  filter_spad_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_len       (cfg_len),
    .cfg_reps      (cfg_reps),
    .cfg_skip_load (cfg_skip_load),
    .cfg_err       (cfg_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .spad_addr     (spad_addr),
    .spad_we       (spad_we),
    .spad_wdata    (spad_wdata),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_last        (w_last),
    .done          (done)
  );

  always #5 clk = ~clk;

  // spad writes and reads on the falling edge
  always @(negedge clk) begin
    if (spad_we) spad_mem[spad_addr] <= spad_wdata;
    spad_dout <= spad_mem[spad_addr];
  end

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outs(string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_spad_we"}, spad_we, 0);
    chk({tag, "_spad_addr"}, spad_addr, 0);
    chk({tag, "_spad_wdata"}, spad_wdata, 0);
    chk({tag, "_w_valid"}, w_valid, 0);
    chk({tag, "_w_last"}, w_last, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk_idle_outs("rst");
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_cmd(int len, int reps, bit skip);
    cfg_valid     = 1'b1;
    cfg_len       = len[7:0];
    cfg_reps      = reps[7:0];
    cfg_skip_load = skip;
    #1;
    chk("cmd_ready", cfg_ready, 1);
    tick();
    cfg_valid     = 1'b0;
    cfg_skip_load = 1'b0;
  endtask

  task automatic bad_cmd(string tag, int len, int reps, bit skip);
    cfg_valid     = 1'b1;
    cfg_len       = len[7:0];
    cfg_reps      = reps[7:0];
    cfg_skip_load = skip;
    #1;
    chk({tag, "_no_we"}, spad_we, 0);
    tick();
    cfg_valid     = 1'b0;
    cfg_skip_load = 1'b0;
    #1;
    chk({tag, "_err"}, cfg_err, 1);
    chk_idle_outs(tag);
    tick();
    chk({tag, "_err_clr"}, cfg_err, 0);
    chk({tag, "_still_idle"}, cfg_ready, 1);
    tick();
  endtask

  task automatic load_words(int len);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = exp_w[i];
      #1;
      chk("ld_we", spad_we, 1);
      chk("ld_addr", spad_addr, i);
      chk("ld_wdata", spad_wdata, exp_w[i]);
      chk("ld_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic read_one(int addr, logic [15:0] w, bit last);
    #1;
    chk("rd_valid", w_valid, 1);
    chk("rd_addr", spad_addr, addr);
    chk("rd_last", w_last, last);
    chk("rd_no_we", spad_we, 0);
    @(negedge clk);
    #1;
    chk("rd_data", spad_dout, w);
    tick();
  endtask

  task automatic chk_done();
    #1;
    chk("done_pulse", done, 1);
    chk("done_no_valid", w_valid, 0);
    chk("done_not_ready", cfg_ready, 0);
    tick();
    chk("done_clr", done, 0);
    chk("done_back_idle", cfg_ready, 1);
  endtask

  task automatic read_words(int len, int reps);
    w_ready = 1'b1;
    for (int k = 0; k < len * reps; k++) begin
      read_one(k % len, exp_w[k % len], k == len * reps - 1);
    end
    w_ready = 1'b0;
    chk_done();
  endtask

  initial begin
    int wc;
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_len = '0; cfg_reps = '0; cfg_skip_load = 1'b0;
    in_valid = 1'b0; in_data = '0; w_ready = 1'b0;
    tick();
    apply_reset();

    // basic load then two replay passes
    exp_w[0] = 16'h0011; exp_w[1] = 16'h0022; exp_w[2] = 16'h0033; exp_w[3] = 16'h0044;
    do_cmd(4, 2, 1'b0);
    load_words(4);
    read_words(4, 2);

    // gapped load: in_valid 1,0,1,0,1
    exp_w[0] = 16'h00A1; exp_w[1] = 16'h00A2; exp_w[2] = 16'h00A3;
    do_cmd(3, 1, 1'b0);
    wc = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = (c % 2 == 0) ? exp_w[wc] : 16'hDEAD;
      #1;
      chk("gap_we", spad_we, in_valid);
      chk("gap_in_ready", in_ready, 1);
      if (in_valid) chk("gap_addr", spad_addr, wc);
      tick();
      if (in_valid) wc++;
    end
    in_valid = 1'b0;
    chk("gap_load_end", in_ready, 0);
    read_words(3, 1);

    // stall for three cycles on the second weight of a skip-load replay
    do_cmd(3, 1, 1'b1);
    chk("skip_no_load", in_ready, 0);
    w_ready = 1'b1;
    read_one(0, 16'h00A1, 1'b0);
    w_ready = 1'b0;
    for (int s = 0; s < 3; s++) read_one(1, 16'h00A2, 1'b0);
    w_ready = 1'b1;
    read_one(1, 16'h00A2, 1'b0);
    read_one(2, 16'h00A3, 1'b1);
    w_ready = 1'b0;
    chk_done();

    // illegal commands after reset
    apply_reset();
    bad_cmd("len0", 0, 1, 1'b0);
    bad_cmd("len225", 225, 1, 1'b0);
    bad_cmd("skip_unloaded", 4, 1, 1'b1);
    bad_cmd("reps0", 4, 0, 1'b0);

    // full-depth load, then three passes reusing the contents
    for (int i = 0; i < 224; i++) exp_w[i] = 16'h5A00 ^ 16'(i * 7);
    do_cmd(224, 1, 1'b0);
    load_words(224);
    read_words(224, 1);
    do_cmd(224, 3, 1'b1);
    chk("full_skip_no_load", in_ready, 0);
    read_words(224, 3);

    // reset mid-replay at pass 1, address 5
    do_cmd(8, 2, 1'b1);
    w_ready = 1'b1;
    for (int k = 0; k < 13; k++) read_one(k % 8, exp_w[k % 8], 1'b0);
    #1;
    chk("abort_addr", spad_addr, 5);
    chk("abort_valid_before", w_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_w_valid", w_valid, 0);
    chk("abort_cfg_ready", cfg_ready, 1);
    chk("abort_addr_zero", spad_addr, 0);
    w_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bad_cmd("skip_after_abort", 8, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
